// File: rtl/inst_buffer_pkg.sv
// Shared types and sizing for the decode-to-dispatch instruction buffer.
package inst_buffer_pkg;

  localparam int unsigned IB_SZ     = 8;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;

  // Decoded instruction handed from decode to dispatch.
  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      npc;
    logic [XLEN-1:0]      inst;
    logic [REG_IDX_W-1:0] dest_reg_idx;
    logic [REG_IDX_W-1:0] rs1_idx;
    logic [REG_IDX_W-1:0] rs2_idx;
    logic                 rd_mem;
    logic                 wr_mem;
    logic                 cond_branch;
    logic                 uncond_branch;
    logic                 halt;
    logic                 illegal;
    logic                 valid;
  } DP_PACKET;

  // Branch-mispredict recovery request.
  typedef struct packed {
    logic            squash_valid;
    logic [XLEN-1:0] squash_pc;
  } SQUASH_PACKET;

endpackage

// File: rtl/inst_buffer_ptr_ctrl.sv
// Head/tail/occupancy tracking and enqueue/dequeue qualification for inst_buffer.
// IB_BYPASS_EN: allow an empty buffer to pass the incoming packet straight through.
module ib_ptr_ctrl
  import inst_buffer_pkg::*;
#(
  parameter int unsigned IB_DEPTH = IB_SZ,
  parameter int unsigned IB_PTR_W = $clog2(IB_DEPTH)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  input  logic                rob_dp_available,
  input  logic                rs_dp_available,
  input  logic                squash_valid,
  output logic [IB_PTR_W-1:0] head,
  output logic [IB_PTR_W-1:0] tail,
  output logic [IB_PTR_W:0]   count,
  output logic                full_c,
  output logic                empty_c,
  output logic                enq_c,
  output logic                deq_c,
  output logic                bypass_c
);

  localparam int unsigned CNT_W = IB_PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(IB_DEPTH);

  logic downstream_ready_c;

  assign full_c             = (count == DEPTH_CNT);
  assign empty_c            = (count == '0);
  assign downstream_ready_c = rob_dp_available & rs_dp_available;

`ifdef IB_BYPASS_EN
  assign bypass_c = empty_c & in_valid & downstream_ready_c & ~squash_valid;
`else
  assign bypass_c = 1'b0;
`endif

  // A bypassed packet goes straight to dispatch and is never stored.
  assign enq_c = in_valid & ~full_c & ~squash_valid & ~bypass_c;
  assign deq_c = ~empty_c & downstream_ready_c & ~squash_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (squash_valid) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_c) tail <= tail + IB_PTR_W'(1);
      if (deq_c) head <= head + IB_PTR_W'(1);
      count <= count + CNT_W'(enq_c) - CNT_W'(deq_c);
    end
  end

endmodule

// File: rtl/inst_buffer.sv
// Circular FIFO of decoded instructions between decode and dispatch, flushed on squash.
// IB_BYPASS_EN: zero-latency pass-through when the buffer is empty and dispatch is ready.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int unsigned IB_DEPTH = IB_SZ,
  parameter int unsigned IB_PTR_W = $clog2(IB_DEPTH)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  input  DP_PACKET            in_packet,
  output logic                in_ready,
  input  logic                rob_dp_available,
  input  logic                rs_dp_available,
  input  SQUASH_PACKET        squash_packet,
  output logic                out_valid,
  output DP_PACKET            out_packet,
  output logic [IB_PTR_W:0]   count
);

  DP_PACKET            mem [IB_DEPTH];
  logic [IB_PTR_W-1:0] head;
  logic [IB_PTR_W-1:0] tail;
  logic                full_c;
  logic                empty_c;
  logic                enq_c;
  logic                deq_c;
  logic                bypass_c;
  logic                squash_valid;
  logic                unused_squash_bits;

  assign squash_valid       = squash_packet.squash_valid;
  assign unused_squash_bits = ^squash_packet.squash_pc;

  ib_ptr_ctrl #(
    .IB_DEPTH (IB_DEPTH),
    .IB_PTR_W (IB_PTR_W)
  ) u_ptr_ctrl (
    .clock            (clock),
    .reset            (reset),
    .in_valid         (in_valid),
    .rob_dp_available (rob_dp_available),
    .rs_dp_available  (rs_dp_available),
    .squash_valid     (squash_valid),
    .head             (head),
    .tail             (tail),
    .count            (count),
    .full_c           (full_c),
    .empty_c          (empty_c),
    .enq_c            (enq_c),
    .deq_c            (deq_c),
    .bypass_c         (bypass_c)
  );

  // Dequeued slots are zeroed so a drained buffer holds nothing stale.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(IB_DEPTH); i++) mem[i] <= '0;
    end else if (squash_valid) begin
      for (int i = 0; i < int'(IB_DEPTH); i++) mem[i] <= '0;
    end else begin
      if (deq_c) mem[head] <= '0;
      if (enq_c) mem[tail] <= in_packet;
    end
  end

  // Ready depends only on registered occupancy, keeping ROB/RS out of decode's path.
  assign in_ready  = ~full_c;
  assign out_valid = deq_c | bypass_c;

  always_comb begin
    out_packet = '0;
    if (bypass_c)      out_packet = in_packet;
    else if (!empty_c) out_packet = mem[head];
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Directed self-checking bench for inst_buffer (honours IB_BYPASS_EN when defined).
`timescale 1ns/1ps
module tb_inst_buffer;
  import inst_buffer_pkg::*;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  DP_PACKET     in_packet;
  logic         in_ready;
  logic         rob_dp_available;
  logic         rs_dp_available;
  SQUASH_PACKET squash_packet;
  logic         out_valid;
  DP_PACKET     out_packet;
  logic [3:0]   count;

  int tests_run    = 0;
  int tests_failed = 0;

  inst_buffer dut (
    .clock            (clock),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_packet        (in_packet),
    .in_ready         (in_ready),
    .rob_dp_available (rob_dp_available),
    .rs_dp_available  (rs_dp_available),
    .squash_packet    (squash_packet),
    .out_valid        (out_valid),
    .out_packet       (out_packet),
    .count            (count)
  );

  always #5 clock = ~clock;

  function automatic DP_PACKET mk_pkt(input logic [31:0] pc);
    DP_PACKET p;
    p              = '0;
    p.pc           = pc;
    p.npc          = pc + 32'd4;
    p.inst         = 32'h0000_0013 ^ {pc[24:0], 7'd0};
    p.dest_reg_idx = pc[6:2];
    p.rs1_idx      = pc[11:7];
    p.valid        = 1'b1;
    return p;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset            = 1'b1;
    in_valid         = 1'b0;
    in_packet        = '0;
    rob_dp_available = 1'b0;
    rs_dp_available  = 1'b0;
    squash_packet    = '0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc);
    @(negedge clock);
    in_valid  = 1'b1;
    in_packet = mk_pkt(pc);
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset            = 1'b1;
    in_valid         = 1'b0;
    in_packet        = '0;
    rob_dp_available = 1'b1;
    rs_dp_available  = 1'b1;
    squash_packet    = '0;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    tests_run++; if (out_packet !== DP_PACKET'('0)) begin tests_failed++; $display("FAIL reset_out_packet got pc=%h exp zero", out_packet.pc); end
    tests_run++; if (count !== 4'd0) begin tests_failed++; $display("FAIL reset_count got %0d exp 0", count); end
    @(negedge clock);
    reset = 1'b0;
    #1;
    tests_run++; if (out_valid !== 1'b0 || count !== 4'd0) begin tests_failed++; $display("FAIL post_reset got valid=%b count=%0d exp 0/0", out_valid, count); end
  endtask

  task automatic test_fill_drain();
    do_reset();
    push(32'h0); push(32'h4); push(32'h8);
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    tests_run++; if (count !== 4'd3) begin tests_failed++; $display("FAIL fd_count got %0d exp 3", count); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL fd_stalled_valid got %b exp 0", out_valid); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      rob_dp_available = 1'b1;
      rs_dp_available  = 1'b1;
      #1;
      tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL fd_out_valid[%0d] got %b exp 1", i, out_valid); end
      tests_run++; if (out_packet !== mk_pkt(32'(4 * i))) begin tests_failed++; $display("FAIL fd_out_pc[%0d] got %h exp %h", i, out_packet.pc, 32'(4 * i)); end
    end
    @(negedge clock);
    #1;
    tests_run++; if (count !== 4'd0) begin tests_failed++; $display("FAIL fd_final_count got %0d exp 0", count); end
    tests_run++; if (out_packet !== DP_PACKET'('0)) begin tests_failed++; $display("FAIL fd_final_packet got pc=%h exp zero", out_packet.pc); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL fd_final_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      push(32'h100 + 32'(4 * i));
      #1;
      tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL full_ready_fill[%0d] got %b exp 1", i, in_ready); end
    end
    push(32'h999);
    #1;
    tests_run++; if (count !== 4'd8) begin tests_failed++; $display("FAIL full_count got %0d exp 8", count); end
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
    // Dequeue while full with a new packet offered: the slot must not be reused this cycle.
    push(32'h998);
    rob_dp_available = 1'b1;
    rs_dp_available  = 1'b1;
    #1;
    tests_run++; if (count !== 4'd8) begin tests_failed++; $display("FAIL full_9th_dropped got count=%0d exp 8", count); end
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL full_deq_ready got %b exp 0", in_ready); end
    tests_run++; if (out_valid !== 1'b1 || out_packet !== mk_pkt(32'h100)) begin tests_failed++; $display("FAIL full_deq_head got valid=%b pc=%h exp 1/100", out_valid, out_packet.pc); end
    @(negedge clock);
    in_valid         = 1'b0;
    rob_dp_available = 1'b0;
    rs_dp_available  = 1'b0;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL full_ready_after got %b exp 1", in_ready); end
    tests_run++; if (count !== 4'd7) begin tests_failed++; $display("FAIL full_count_after got %0d exp 7", count); end
    for (int i = 1; i < 8; i++) begin
      @(negedge clock);
      rob_dp_available = 1'b1;
      rs_dp_available  = 1'b1;
      #1;
      tests_run++; if (out_packet !== mk_pkt(32'h100 + 32'(4 * i))) begin tests_failed++; $display("FAIL full_drain[%0d] got %h exp %h", i, out_packet.pc, 32'h100 + 32'(4 * i)); end
    end
    @(negedge clock);
    #1;
    tests_run++; if (count !== 4'd0 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL full_drained got count=%0d valid=%b exp 0/0", count, out_valid); end
  endtask

  task automatic test_stream();
    do_reset();
    push(32'h400);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      rob_dp_available = 1'b1;
      rs_dp_available  = 1'b1;
      in_valid         = (i < 20);
      in_packet        = mk_pkt(32'h400 + 32'(4 * i));
      #1;
      tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL stream_valid[%0d] got %b exp 1", i, out_valid); end
      tests_run++; if (out_packet !== mk_pkt(32'h400 + 32'(4 * (i - 1)))) begin tests_failed++; $display("FAIL stream_order[%0d] got %h exp %h", i, out_packet.pc, 32'h400 + 32'(4 * (i - 1))); end
      tests_run++; if (count !== 4'd1) begin tests_failed++; $display("FAIL stream_count[%0d] got %0d exp 1", i, count); end
    end
    @(negedge clock);
    #1;
    tests_run++; if (count !== 4'd0) begin tests_failed++; $display("FAIL stream_final_count got %0d exp 0", count); end
  endtask

  task automatic test_squash();
    do_reset();
    for (int i = 0; i < 5; i++) push(32'h500 + 32'(4 * i));
    push(32'hDEAD);
    squash_packet.squash_valid = 1'b1;
    squash_packet.squash_pc    = 32'h8000;
    rob_dp_available = 1'b1;
    rs_dp_available  = 1'b1;
    #1;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL squash_out_valid got %b exp 0", out_valid); end
    @(negedge clock);
    squash_packet    = '0;
    in_valid         = 1'b0;
    #1;
    tests_run++; if (count !== 4'd0) begin tests_failed++; $display("FAIL squash_count got %0d exp 0", count); end
    tests_run++; if (dut.u_ptr_ctrl.head !== 3'd0 || dut.u_ptr_ctrl.tail !== 3'd0) begin tests_failed++; $display("FAIL squash_ptrs got head=%0d tail=%0d exp 0/0", dut.u_ptr_ctrl.head, dut.u_ptr_ctrl.tail); end
    tests_run++; if (out_valid !== 1'b0 || out_packet !== DP_PACKET'('0)) begin tests_failed++; $display("FAIL squash_empty_out got valid=%b pc=%h exp 0/zero", out_valid, out_packet.pc); end
    rob_dp_available = 1'b0;
    rs_dp_available  = 1'b0;
    push(32'h600);
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    tests_run++; if (count !== 4'd1 || out_packet !== mk_pkt(32'h600)) begin tests_failed++; $display("FAIL squash_restart got count=%0d pc=%h exp 1/600", count, out_packet.pc); end
  endtask

  task automatic test_partial_avail();
    do_reset();
    push(32'h200); push(32'h204);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      in_valid         = 1'b0;
      rob_dp_available = (i != 3);
      rs_dp_available  = (i == 3);
      #1;
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL partial_valid[%0d] got %b exp 0", i, out_valid); end
      tests_run++; if (count !== 4'd2 || out_packet !== mk_pkt(32'h200)) begin tests_failed++; $display("FAIL partial_hold[%0d] got count=%0d pc=%h exp 2/200", i, count, out_packet.pc); end
    end
  endtask

  task automatic test_latency();
    do_reset();
    @(negedge clock);
    rob_dp_available = 1'b1;
    rs_dp_available  = 1'b1;
    in_valid         = 1'b1;
    in_packet        = mk_pkt(32'h300);
    #1;
`ifdef IB_BYPASS_EN
    tests_run++; if (out_valid !== 1'b1 || out_packet !== mk_pkt(32'h300)) begin tests_failed++; $display("FAIL bypass_same_cycle got valid=%b pc=%h exp 1/300", out_valid, out_packet.pc); end
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    tests_run++; if (count !== 4'd0 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL bypass_no_store got count=%0d valid=%b exp 0/0", count, out_valid); end
`else
    tests_run++; if (out_valid !== 1'b0 || out_packet !== DP_PACKET'('0)) begin tests_failed++; $display("FAIL lat_same_cycle got valid=%b pc=%h exp 0/zero", out_valid, out_packet.pc); end
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    tests_run++; if (out_valid !== 1'b1 || out_packet !== mk_pkt(32'h300)) begin tests_failed++; $display("FAIL lat_next_cycle got valid=%b pc=%h exp 1/300", out_valid, out_packet.pc); end
    @(negedge clock);
    #1;
    tests_run++; if (count !== 4'd0) begin tests_failed++; $display("FAIL lat_drained got count=%0d exp 0", count); end
`endif
  endtask

  task automatic test_invalid_entry_and_reset();
    DP_PACKET bubble;
    do_reset();
    bubble       = mk_pkt(32'h700);
    bubble.valid = 1'b0;
    @(negedge clock);
    in_valid  = 1'b1;
    in_packet = bubble;
    push(32'h704);
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    tests_run++; if (count !== 4'd2 || out_packet !== bubble) begin tests_failed++; $display("FAIL bubble_buffered got count=%0d pc=%h exp 2/700", count, out_packet.pc); end
    reset = 1'b1;
    #1;
    tests_run++; if (count !== 4'd0 || in_ready !== 1'b1 || out_packet !== DP_PACKET'('0)) begin tests_failed++; $display("FAIL midop_reset got count=%0d ready=%b pc=%h exp 0/1/zero", count, in_ready, out_packet.pc); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fill_drain();
    test_full();
    test_stream();
    test_squash();
    test_partial_avail();
    test_latency();
    test_invalid_entry_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
